// File: rtl/dut_sweep_sequencer.sv
// Autonomous read-sweep controller. Takes one command (DUT select plus an
// inclusive address range). For each address it issues a read to the selected
// DUT, waits for the ready level (bounded by a timeout), and streams each
// result word out over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   cmd_*                command handshake: select, first/last address
//   abort_i              synchronous abort of a running sweep
//   dut_*                read transaction interface toward the DUT bank
//   res_*                result stream: data, address, timeout flag
//   busy_o, done_o       status; done_o pulses once when a sweep completes
module dut_sweep_sequencer #(
  parameter int unsigned NumDut        = 3,
  parameter int unsigned BitwidthData  = 16,
  parameter int unsigned BitwidthAdr   = 6,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned SelW         = (NumDut > 1) ? $clog2(NumDut) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [SelW-1:0]         cmd_sel_i,
  input  logic [BitwidthAdr-1:0]  cmd_adr_first_i,
  input  logic [BitwidthAdr-1:0]  cmd_adr_last_i,
  input  logic                    abort_i,
  output logic                    dut_start_o,
  output logic [SelW-1:0]         dut_sel_o,
  output logic [BitwidthAdr-1:0]  dut_adr_o,
  output logic                    dut_rnw_o,
  input  logic [BitwidthData-1:0] dut_dout_i,
  input  logic                    dut_rdy_i,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [BitwidthData-1:0] res_data_o,
  output logic [BitwidthAdr-1:0]  res_adr_o,
  output logic                    res_timeout_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int unsigned CntW = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StGuard,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e                  state_q;
  logic [SelW-1:0]         dut_sel_q;
  logic [BitwidthAdr-1:0]  dut_adr_q;
  logic [BitwidthAdr-1:0]  adr_last_q;
  logic [BitwidthAdr-1:0]  res_adr_q;
  logic [BitwidthData-1:0] res_data_q;
  logic [CntW-1:0]         tmo_cnt_q;
  logic                    dut_start_q;
  logic                    res_valid_q;
  logic                    res_timeout_q;
  logic                    cmd_ready_q;
  logic                    busy_q;
  logic                    done_q;

  // Outputs are registered alongside the state so each one is valid in the
  // same cycle as the state it belongs to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      dut_sel_q     <= '0;
      dut_adr_q     <= '0;
      adr_last_q    <= '0;
      res_adr_q     <= '0;
      res_data_q    <= '0;
      tmo_cnt_q     <= '0;
      dut_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      dut_start_q <= 1'b0;
      done_q      <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        // Abort beats every transition, including a same-cycle transfer.
        state_q     <= StIdle;
        res_valid_q <= 1'b0;
        cmd_ready_q <= 1'b1;
        busy_q      <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (cmd_valid_i) begin
              dut_sel_q   <= cmd_sel_i;
              dut_adr_q   <= cmd_adr_first_i;
              adr_last_q  <= cmd_adr_last_i;
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              if (cmd_adr_first_i > cmd_adr_last_i) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                state_q     <= StIssue;
                dut_start_q <= 1'b1;
              end
            end
          end
          StIssue: begin
            tmo_cnt_q <= '0;
            state_q   <= StGuard;
          end
          // The DUT may still present the previous ready level here.
          StGuard: state_q <= StWait;
          StWait: begin
            if (dut_rdy_i) begin
              res_data_q    <= dut_dout_i;
              res_timeout_q <= 1'b0;
              res_adr_q     <= dut_adr_q;
              res_valid_q   <= 1'b1;
              state_q       <= StEmit;
            end else if (tmo_cnt_q == TmoLast) begin
              res_data_q    <= '0;
              res_timeout_q <= 1'b1;
              res_adr_q     <= dut_adr_q;
              res_valid_q   <= 1'b1;
              state_q       <= StEmit;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CntW'(1);
            end
          end
          StEmit: begin
            if (res_ready_i) begin
              res_valid_q <= 1'b0;
              // Compare before incrementing so the top address never wraps.
              if (dut_adr_q == adr_last_q) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end else begin
                dut_adr_q   <= dut_adr_q + BitwidthAdr'(1);
                state_q     <= StIssue;
                dut_start_q <= 1'b1;
              end
            end
          end
          StDone: begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
          default: begin
            state_q     <= StIdle;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign dut_start_o   = dut_start_q;
  assign dut_sel_o     = dut_sel_q;
  assign dut_adr_o     = dut_adr_q;
  assign dut_rnw_o     = 1'b1;
  assign res_valid_o   = res_valid_q;
  assign res_data_o    = res_data_q;
  assign res_adr_o     = res_adr_q;
  assign res_timeout_o = res_timeout_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_dut_sweep_sequencer.sv
// Directed bench for dut_sweep_sequencer: reset, basic sweep, backpressure,
// timeout, empty and top-address sweeps, abort and ignored command.
module tb_dut_sweep_sequencer;

  localparam int unsigned NumDut = 3;
  localparam int unsigned Bd     = 16;
  localparam int unsigned Ba     = 6;
  localparam int unsigned Tmo    = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_sel;
  logic [Ba-1:0] cmd_first;
  logic [Ba-1:0] cmd_last;
  logic          abort;
  logic          dut_start;
  logic [1:0]    dut_sel;
  logic [Ba-1:0] dut_adr;
  logic          dut_rnw;
  logic [Bd-1:0] dut_dout = '0;
  logic          dut_rdy = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [Bd-1:0] res_data;
  logic [Ba-1:0] res_adr;
  logic          res_timeout;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dut_sweep_sequencer #(
    .NumDut       (NumDut),
    .BitwidthData (Bd),
    .BitwidthAdr  (Ba),
    .TimeoutCycles(Tmo)
  ) u_dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_sel_i      (cmd_sel),
    .cmd_adr_first_i(cmd_first),
    .cmd_adr_last_i (cmd_last),
    .abort_i        (abort),
    .dut_start_o    (dut_start),
    .dut_sel_o      (dut_sel),
    .dut_adr_o      (dut_adr),
    .dut_rnw_o      (dut_rnw),
    .dut_dout_i     (dut_dout),
    .dut_rdy_i      (dut_rdy),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready),
    .res_data_o     (res_data),
    .res_adr_o      (res_adr),
    .res_timeout_o  (res_timeout),
    .busy_o         (busy),
    .done_o         (done)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // DUT model: ready rises 3 cycles after START with 0xA000+adr. The old
  // ready level lingers through the START and guard cycles.
  int age      = 1000;
  int lat_adr  = 0;
  int hang_adr = -1;
  always @(negedge clk) begin
    if (dut_start === 1'b1) begin
      age     = 0;
      lat_adr = int'(dut_adr);
    end else if (age < 1000) begin
      age++;
    end
    if (age == 2) begin
      dut_rdy = 1'b0;
    end else if (age == 3) begin
      if (lat_adr == hang_adr) begin
        dut_dout = 16'hDEAD;
      end else begin
        dut_rdy  = 1'b1;
        dut_dout = 16'hA000 + 16'(lat_adr);
      end
    end
  end

  // Consumer: always ready, or in backpressure mode 5 stall cycles per result.
  bit bp_mode = 1'b0;
  int hold    = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (!bp_mode) begin
      res_ready = 1'b1;
    end else if (res_valid !== 1'b1) begin
      hold      = 0;
      res_ready = 1'b0;
    end else begin
      res_ready = (hold >= 5);
      hold++;
    end
  end

  // Monitor: counts events and records transferred results.
  int cyc = 0, n_start = 0, n_done = 0, n_valid = 0, stab_err = 0, sel_err = 0;
  int last_start_cyc = 0, last_xfer_cyc = 0, done_cyc = 0;
  int exp_sel = 0;
  logic [Ba-1:0] r_adr_q[$];
  logic [Bd-1:0] r_data_q[$];
  logic          r_tmo_q[$];
  int            lat_q[$];
  logic          prev_valid = 1'b0;
  logic          prev_xfer = 1'b0;
  logic [Bd-1:0] prev_data = '0;
  logic [Ba-1:0] prev_adr = '0;
  logic          prev_tmo = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (dut_start === 1'b1) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (res_valid === 1'b1) begin
      n_valid++;
      if (!prev_valid || prev_xfer) begin
        lat_q.push_back(cyc - last_start_cyc);
      end else if (res_data !== prev_data || res_adr !== prev_adr || res_timeout !== prev_tmo) begin
        stab_err++;
      end
      if (res_ready) begin
        r_adr_q.push_back(res_adr);
        r_data_q.push_back(res_data);
        r_tmo_q.push_back(res_timeout);
        last_xfer_cyc = cyc;
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
    if (busy === 1'b1 && int'(dut_sel) != exp_sel) sel_err++;
    prev_valid = (res_valid === 1'b1);
    prev_xfer  = (res_valid === 1'b1) && res_ready;
    prev_data  = res_data;
    prev_adr   = res_adr;
    prev_tmo   = res_timeout;
  end

  int b_start, b_done, b_valid, b_res, b_lat, b_stab, b_sel;

  task automatic snap();
    b_start = n_start;
    b_done  = n_done;
    b_valid = n_valid;
    b_res   = r_adr_q.size();
    b_lat   = lat_q.size();
    b_stab  = stab_err;
    b_sel   = sel_err;
  endtask

  task automatic run_cmd(input int sel, input int first, input int last);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_sel   = 2'(sel);
    cmd_first = 6'(first);
    cmd_last  = 6'(last);
    exp_sel   = sel;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int k = 0;
    while (n_done == b_done && k < max) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(n_done != b_done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_res(input string tag, input int idx, input int adr, input int data,
                           input int tmo);
    check({tag, "_adr"}, 32'(r_adr_q[idx]), 32'(adr));
    check({tag, "_data"}, 32'(r_data_q[idx]), 32'(data));
    check({tag, "_tmo"}, 32'(r_tmo_q[idx]), 32'(tmo));
  endtask

  bit found;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_sel   = '0;
    cmd_first = '0;
    cmd_last  = '0;
    abort     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dut_start", 32'(dut_start), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dut_rnw", 32'(dut_rnw), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_dut_start", 32'(dut_start), 32'd0);

    // Basic sweep 4..6 on DUT 2
    snap();
    run_cmd(2, 4, 6);
    wait_done("basic_done_seen", 200);
    check("basic_count", 32'(r_adr_q.size() - b_res), 32'd3);
    check_res("basic_r0", b_res + 0, 4, 'hA004, 0);
    check_res("basic_r1", b_res + 1, 5, 'hA005, 0);
    check_res("basic_r2", b_res + 2, 6, 'hA006, 0);
    check("basic_starts", 32'(n_start - b_start), 32'd3);
    check("basic_done_pulses", 32'(n_done - b_done), 32'd1);
    check("basic_done_after_xfer", 32'(done_cyc - last_xfer_cyc), 32'd1);
    check("basic_latency", 32'(lat_q[b_lat]), 32'd4);
    check("basic_sel_stable", 32'(sel_err - b_sel), 32'd0);
    check("basic_idle_ready", 32'(cmd_ready), 32'd1);
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Same sweep with 5 stall cycles per result
    bp_mode = 1'b1;
    snap();
    run_cmd(2, 4, 6);
    wait_done("bp_done_seen", 300);
    bp_mode = 1'b0;
    check("bp_count", 32'(r_adr_q.size() - b_res), 32'd3);
    check_res("bp_r0", b_res + 0, 4, 'hA004, 0);
    check_res("bp_r1", b_res + 1, 5, 'hA005, 0);
    check_res("bp_r2", b_res + 2, 6, 'hA006, 0);
    check("bp_starts", 32'(n_start - b_start), 32'd3);
    check("bp_stable", 32'(stab_err - b_stab), 32'd0);
    check("bp_valid_cycles", 32'(n_valid - b_valid), 32'd18);
    check("bp_done_pulses", 32'(n_done - b_done), 32'd1);

    // Timeout at adr 5, then adr 6 completes normally
    hang_adr = 5;
    snap();
    run_cmd(1, 5, 6);
    wait_done("tmo_done_seen", 300);
    hang_adr = -1;
    check("tmo_count", 32'(r_adr_q.size() - b_res), 32'd2);
    check_res("tmo_r0", b_res + 0, 5, 0, 1);
    check_res("tmo_r1", b_res + 1, 6, 'hA006, 0);
    check("tmo_latency", 32'(lat_q[b_lat]), 32'd10);
    check("tmo_next_latency", 32'(lat_q[b_lat + 1]), 32'd4);
    check("tmo_starts", 32'(n_start - b_start), 32'd2);

    // Empty sweep: first > last
    snap();
    run_cmd(0, 7, 3);
    wait_done("empty_done_seen", 50);
    check("empty_starts", 32'(n_start - b_start), 32'd0);
    check("empty_valid", 32'(n_valid - b_valid), 32'd0);
    check("empty_done_pulses", 32'(n_done - b_done), 32'd1);

    // Single top address: no wrap to 0
    snap();
    run_cmd(2, 63, 63);
    wait_done("top_done_seen", 100);
    repeat (10) @(negedge clk);
    check("top_count", 32'(r_adr_q.size() - b_res), 32'd1);
    check_res("top_r0", b_res, 63, 'hA03F, 0);
    check("top_starts", 32'(n_start - b_start), 32'd1);
    check("top_done_pulses", 32'(n_done - b_done), 32'd1);

    // Ignored command while busy, then abort during WAIT at adr 5
    hang_adr = 5;
    snap();
    run_cmd(1, 4, 10);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_sel   = 2'd2;
    cmd_first = 6'd0;
    cmd_last  = 6'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("ign_dut_sel", 32'(dut_sel), 32'd1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      found = (dut_start === 1'b1) && (dut_adr == 6'd5);
    end
    check("abort_reach_adr5", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    repeat (20) @(negedge clk);
    hang_adr = -1;
    check("abort_starts", 32'(n_start - b_start), 32'd2);
    check("abort_no_done", 32'(n_done - b_done), 32'd0);
    check("abort_count", 32'(r_adr_q.size() - b_res), 32'd1);
    check_res("abort_r0", b_res, 4, 'hA004, 0);
    check("abort_sel_stable", 32'(sel_err - b_sel), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
